bbq_op_scheduler: RTL

Ingress stage directly upstream of the BBQ router. It buffers enqueue requests and dequeue requests in two small FIFOs and combines them into at most one heap "slot" per cycle, an enqueue/dequeue pair. It drives the router's `bbq_rdy`, `in_enque_en`, `in_data`, `in_prior`, `out_ctrl` and `out_op` inputs, and alternates port assignment between slots.

---
 rtl/bbq_op_scheduler.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/bbq_op_scheduler.sv
// bbq_op_scheduler
// Ingress stage in front of the BBQ router. Enqueue requests ({data, prior})
// and dequeue requests (op codes) are buffered in two independent FIFOs. Each
// cycle at most one heap slot is issued, carrying the enqueue FIFO head and the
// dequeue FIFO head together. The enqueue port alternates between slots.
//
// Ports
//   clk, rst        single clock, synchronous active-high reset
//   enq_valid/ready enqueue request handshake, enq_data / enq_prior payload
//   deq_valid/ready dequeue request handshake, deq_op operation code
//   idle_op         op driven on slots that carry no dequeue (heap no-op)
//   heap_ready      heap can take a slot this cycle
//   router_rdy      a slot is issued this cycle
//   in_enque_en     the issued slot carries an enqueue
//   in_data/in_prior enqueue FIFO head (zero when the FIFO is empty)
//   out_ctrl        port select for the enqueue, toggles per issued slot
//   out_op          dequeue op of the issued slot, else idle_op
//
// Outputs depend only on registered state plus heap_ready and idle_op; the
// request valids never reach an output combinationally (no bypass).
module bbq_op_scheduler #(
    parameter int DWIDTH      = 32,
    parameter int PRIOR_WIDTH = 6,
    parameter int ENQ_DEPTH   = 8,
    parameter int DEQ_DEPTH   = 4,
    parameter int OP_WIDTH    = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enq_valid,
    output logic                   enq_ready,
    input  logic [DWIDTH-1:0]      enq_data,
    input  logic [PRIOR_WIDTH-1:0] enq_prior,
    input  logic                   deq_valid,
    output logic                   deq_ready,
    input  logic [OP_WIDTH-1:0]    deq_op,
    input  logic [OP_WIDTH-1:0]    idle_op,
    input  logic                   heap_ready,
    output logic                   router_rdy,
    output logic                   in_enque_en,
    output logic [DWIDTH-1:0]      in_data,
    output logic [PRIOR_WIDTH-1:0] in_prior,
    output logic                   out_ctrl,
    output logic [OP_WIDTH-1:0]    out_op
);

    localparam int EAW = $clog2(ENQ_DEPTH);
    localparam int DAW = $clog2(DEQ_DEPTH);
    localparam int EW  = DWIDTH + PRIOR_WIDTH;

    localparam logic [EAW:0]   ENQ_FULL  = (EAW+1)'(ENQ_DEPTH);
    localparam logic [DAW:0]   DEQ_FULL  = (DAW+1)'(DEQ_DEPTH);
    localparam logic [EAW:0]   ENQ_CONE  = (EAW+1)'(1);
    localparam logic [DAW:0]   DEQ_CONE  = (DAW+1)'(1);
    localparam logic [EAW-1:0] ENQ_PONE  = EAW'(1);
    localparam logic [DAW-1:0] DEQ_PONE  = DAW'(1);

    logic [EW-1:0]       enq_mem_r [ENQ_DEPTH];
    logic [EAW-1:0]      enq_wr_ptr_r;
    logic [EAW-1:0]      enq_rd_ptr_r;
    logic [EAW:0]        enq_count_r;
    logic [OP_WIDTH-1:0] deq_mem_r [DEQ_DEPTH];
    logic [DAW-1:0]      deq_wr_ptr_r;
    logic [DAW-1:0]      deq_rd_ptr_r;
    logic [DAW:0]        deq_count_r;
    logic                out_ctrl_r;

    logic          enq_nempty_s;
    logic          deq_nempty_s;
    logic          enq_push_s;
    logic          deq_push_s;
    logic          enq_pop_s;
    logic          deq_pop_s;
    logic [EW-1:0] enq_head_s;

    // Readiness and slot issue are derived from registered counts only, so a
    // full FIFO refuses a push even when it pops in the same cycle.
    assign enq_nempty_s = (enq_count_r != {(EAW+1){1'b0}});
    assign deq_nempty_s = (deq_count_r != {(DAW+1){1'b0}});
    assign enq_ready    = (enq_count_r != ENQ_FULL);
    assign deq_ready    = (deq_count_r != DEQ_FULL);
    assign router_rdy   = heap_ready && (enq_nempty_s || deq_nempty_s);
    assign enq_push_s   = enq_valid && enq_ready;
    assign deq_push_s   = deq_valid && deq_ready;
    assign enq_pop_s    = router_rdy && enq_nempty_s;
    assign deq_pop_s    = router_rdy && deq_nempty_s;
    assign enq_head_s   = enq_mem_r[enq_rd_ptr_r];
    assign in_enque_en  = enq_pop_s;
    assign out_ctrl     = out_ctrl_r;

    // Slot payload muxing: head data shown whenever buffered, op only on issue.
    always_comb begin
        in_data  = {DWIDTH{1'b0}};
        in_prior = {PRIOR_WIDTH{1'b0}};
        out_op   = idle_op;
        if (enq_nempty_s) begin
            in_data  = enq_head_s[EW-1:PRIOR_WIDTH];
            in_prior = enq_head_s[PRIOR_WIDTH-1:0];
        end else begin
            in_data  = {DWIDTH{1'b0}};
            in_prior = {PRIOR_WIDTH{1'b0}};
        end
        if (deq_pop_s) begin
            out_op = deq_mem_r[deq_rd_ptr_r];
        end else begin
            out_op = idle_op;
        end
    end

    // FIFO storage writes; contents need no reset because counts gate them.
    always_ff @(posedge clk) begin
        if (enq_push_s) begin
            enq_mem_r[enq_wr_ptr_r] <= {enq_data, enq_prior};
        end
        if (deq_push_s) begin
            deq_mem_r[deq_wr_ptr_r] <= deq_op;
        end
    end

    // Enqueue FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            enq_wr_ptr_r <= {EAW{1'b0}};
            enq_rd_ptr_r <= {EAW{1'b0}};
            enq_count_r  <= {(EAW+1){1'b0}};
        end else begin
            if (enq_push_s) enq_wr_ptr_r <= enq_wr_ptr_r + ENQ_PONE;
            if (enq_pop_s)  enq_rd_ptr_r <= enq_rd_ptr_r + ENQ_PONE;
            case ({enq_push_s, enq_pop_s})
                2'b10:   enq_count_r <= enq_count_r + ENQ_CONE;
                2'b01:   enq_count_r <= enq_count_r - ENQ_CONE;
                default: enq_count_r <= enq_count_r;
            endcase
        end
    end

    // Dequeue FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            deq_wr_ptr_r <= {DAW{1'b0}};
            deq_rd_ptr_r <= {DAW{1'b0}};
            deq_count_r  <= {(DAW+1){1'b0}};
        end else begin
            if (deq_push_s) deq_wr_ptr_r <= deq_wr_ptr_r + DEQ_PONE;
            if (deq_pop_s)  deq_rd_ptr_r <= deq_rd_ptr_r + DEQ_PONE;
            case ({deq_push_s, deq_pop_s})
                2'b10:   deq_count_r <= deq_count_r + DEQ_CONE;
                2'b01:   deq_count_r <= deq_count_r - DEQ_CONE;
                default: deq_count_r <= deq_count_r;
            endcase
        end
    end

    // Port select alternates on every issued slot and holds through stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_ctrl_r <= 1'b0;
        end else if (router_rdy) begin
            out_ctrl_r <= ~out_ctrl_r;
        end else begin
            out_ctrl_r <= out_ctrl_r;
        end
    end

endmodule
